// File: rtl/conv1_ctrl.sv
// rtl/conv1_ctrl.sv - conv1 sliding-window sequencer: image RAM reads, MAC controls, f2 writes
// Walks a KxK window over the image, one tap per cycle, and retires each output pixel into f2.
module conv1_ctrl #(
  parameter int IMG_W = 32,
  parameter int K     = 5,
  parameter int OUT_W = 28
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic [9:0] o_img_raddr,
  output logic       o_img_ren,
  output logic [4:0] o_w_idx,
  output logic       o_mac_clr,
  output logic       o_mac_en,
  output logic       o_f2_wen,
  output logic [9:0] o_f2_waddr
);
  localparam int KW = $clog2(K);
  localparam int CW = $clog2(OUT_W);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [CW-1:0] O_LAST = CW'(OUT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  // r_* counters always describe the tap currently shown on o_img_raddr
  logic [KW-1:0] r_kx, r_ky, w_kx_nxt, w_ky_nxt;
  logic [CW-1:0] r_ox, r_oy, w_ox_nxt, w_oy_nxt;
  logic          w_run, w_tap_first, w_tap_last, w_frame_last;
  logic [9:0]    w_raddr_nxt, w_pix_addr;
  logic [4:0]    w_tap_idx;
  logic          r_p1_last, r_p2_last;
  logic [9:0]    r_p1_addr, r_p2_addr;

  assign w_run        = (r_state == S_RUN);
  assign w_tap_first  = (r_kx == '0) && (r_ky == '0);
  assign w_tap_last   = (r_kx == K_LAST) && (r_ky == K_LAST);
  assign w_frame_last = w_tap_last && (r_ox == O_LAST) && (r_oy == O_LAST);
  assign w_tap_idx    = 5'(r_ky) * 5'(K) + 5'(r_kx);
  assign w_pix_addr   = 10'(r_oy) * 10'(OUT_W) + 10'(r_ox);
  assign w_raddr_nxt  = (10'(w_oy_nxt) + 10'(w_ky_nxt)) * 10'(IMG_W)
                      + 10'(w_ox_nxt) + 10'(w_kx_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_kx_nxt    = r_kx;
    w_ky_nxt    = r_ky;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    case (r_state)
      S_IDLE: begin
        // the done cycle is still part of the previous frame, so start is refused there
        if (i_start && !o_done) begin
          w_state_nxt = S_RUN;
          w_kx_nxt    = '0;
          w_ky_nxt    = '0;
          w_ox_nxt    = '0;
          w_oy_nxt    = '0;
        end
      end
      S_RUN: begin
        if (w_frame_last) begin
          w_state_nxt = S_DRAIN;
          w_kx_nxt    = '0;
          w_ky_nxt    = '0;
          w_ox_nxt    = '0;
          w_oy_nxt    = '0;
        end else if (r_kx != K_LAST) begin
          w_kx_nxt = r_kx + KW'(1);
        end else begin
          w_kx_nxt = '0;
          if (r_ky != K_LAST) begin
            w_ky_nxt = r_ky + KW'(1);
          end else begin
            w_ky_nxt = '0;
            if (r_ox != O_LAST) begin
              w_ox_nxt = r_ox + CW'(1);
            end else begin
              w_ox_nxt = '0;
              w_oy_nxt = r_oy + CW'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        // only the final pixel's write lands while draining
        if (o_f2_wen) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_kx    <= '0;
      r_ky    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_kx    <= w_kx_nxt;
      r_ky    <= w_ky_nxt;
      r_ox    <= w_ox_nxt;
      r_oy    <= w_oy_nxt;
    end
  end

  // Stage 1 matches the RAM read; stages 2/3 cover the MAC and bias/ReLU registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_img_ren   <= 1'b0;
      o_img_raddr <= '0;
      o_mac_en    <= 1'b0;
      o_mac_clr   <= 1'b0;
      o_w_idx     <= '0;
      r_p1_last   <= 1'b0;
      r_p1_addr   <= '0;
      r_p2_last   <= 1'b0;
      r_p2_addr   <= '0;
      o_f2_wen    <= 1'b0;
      o_f2_waddr  <= '0;
    end else begin
      o_busy      <= (w_state_nxt != S_IDLE);
      o_done      <= (r_state == S_DRAIN) && o_f2_wen;
      o_img_ren   <= (w_state_nxt == S_RUN);
      o_img_raddr <= (w_state_nxt == S_RUN) ? w_raddr_nxt : '0;
      o_mac_en    <= w_run;
      o_mac_clr   <= w_run && w_tap_first;
      o_w_idx     <= w_run ? w_tap_idx : '0;
      r_p1_last   <= w_run && w_tap_last;
      r_p1_addr   <= w_pix_addr;
      r_p2_last   <= r_p1_last;
      r_p2_addr   <= r_p1_addr;
      o_f2_wen    <= r_p2_last;
      o_f2_waddr  <= r_p2_addr;
    end
  end

endmodule

// File: doc/conv1_ctrl.md
CONV1_CTRL -- requirements
Module: conv1_ctrl

Interface
REQ-001 Parameter IMG_W, default 32: input image width and height in pixels.
REQ-002 Parameter K, default 5: kernel width and height.
REQ-003 Parameter OUT_W, default 28: output map width and height; equals IMG_W-K+1.
REQ-004 clk  input  1  single clock; all state on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to process one 32x32 image.
REQ-007 busy  output  1  high from the accepted start until done.
REQ-008 done  output  1  one-cycle pulse at the end of a frame.
REQ-009 img_raddr  output  10  image RAM read address, (row*IMG_W + col).
REQ-010 img_ren  output  1  image RAM read enable.
REQ-011 w_idx  output  5  kernel tap index (ky*K + kx), aligned with the returned image data.
REQ-012 mac_clr  output  1  load accumulator with the current product (first tap), aligned with the data.
REQ-013 mac_en  output  1  accumulate the current product, aligned with the data.
REQ-014 f2_wen  output  1  shared write enable for all six f2 feature-map RAMs.
REQ-015 f2_waddr  output  10  f2 write address, (oy*OUT_W + ox).

Function
REQ-016 The block SHALL implement the FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-017 IDLE: start=1 SHALL enter RUN on the next edge with oy=ox=ky=kx=0.
REQ-018 RUN: one tap SHALL issue per cycle, with img_ren=1 and img_raddr=(oy+ky)*IMG_W+(ox+kx).
REQ-019 Tap order SHALL be kx fastest, then ky, then ox, then oy, with no bubble between pixels.
REQ-020 Pixel (oy,ox) SHALL occupy exactly K*K=25 consecutive issue cycles; a frame SHALL take 784*25=19600 issue cycles.
REQ-021 Image RAM read latency is fixed at 1 cycle.
REQ-022 w_idx, mac_clr and mac_en SHALL lag the issued address by 1 cycle (1-stage pipeline).
REQ-023 mac_en SHALL be high for every tap; mac_clr SHALL be high only on tap 0 of each pixel.
REQ-024 f2_wen SHALL pulse for one cycle 3 cycles after the last-tap issue (tap 24) of each pixel.
 - This accounts for 1 cycle of RAM read, 1 cycle of MAC register and 1 cycle of bias/ReLU/quantise register.
REQ-025 f2_waddr SHALL equal that pixel's oy*OUT_W+ox in the f2_wen cycle, carried through a 3-deep pipeline.
REQ-026 After tap 24 of pixel (27,27), the FSM SHALL enter DRAIN and drive img_ren=0.
REQ-027 DRAIN SHALL last until the final f2_wen has been issued.
REQ-028 done SHALL pulse in the cycle after the final f2_wen; in that same cycle busy SHALL fall and the FSM SHALL return to IDLE.
REQ-029 busy SHALL be high in RUN and DRAIN.
REQ-030 start while busy=1 SHALL be ignored, with no queuing; start in the done cycle SHALL also be ignored.
REQ-031 Counter wrap: kx 4->0 increments ky; ky 4->0 increments ox; ox 27->0 increments oy.
REQ-032 Address and index arithmetic SHALL be unsigned, and no output address SHALL exceed 1023 (img) or 783 (f2).
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n=0 SHALL immediately force the FSM to IDLE and clear all counters and pipeline stages.
REQ-035 rst_n=0 SHALL immediately drive busy, done, img_ren, mac_clr, mac_en and f2_wen to 0, and img_raddr, w_idx and f2_waddr to 0.
REQ-036 Reset mid-frame SHALL abort the frame with no further f2_wen and no done; the next start SHALL begin at pixel (0,0).

Verification
REQ-037 Single frame: start pulse at cycle 0 -> busy=1 at cycle 1; first img_raddr=0 at cycle 1; mac_clr=1 with w_idx=0 at cycle 2; first f2_wen with f2_waddr=0 at cycle 28; done 1 cycle after the 784th f2_wen.
REQ-038 Address walk: for pixel (1,27), tap 24 -> img_raddr=(1+4)*32+(27+4)=191; for pixel (27,27), tap 24 -> img_raddr=1023; the final f2_waddr=783.
REQ-039 Tap pattern: every 25-cycle window SHALL show mac_en high for 25 cycles and mac_clr high only on its first cycle; count exactly 784 mac_clr and 784 f2_wen pulses per frame.
REQ-040 Start while busy: extra start pulses at issue cycles 100 and 19599 -> no effect on addresses; exactly one done.
REQ-041 Mid-frame reset: assert rst_n=0 at issue cycle 5000 -> all outputs 0 asynchronously; after release plus start, the frame restarts at img_raddr=0 and completes normally.
REQ-042 Back-to-back: start in the cycle after done -> a second frame runs with an identical output trace, shifted in time.
